// File: rtl/control_pkg.sv
// Shared encodings, state/opcode types and the idle control vector for the control_unit sequencer.
// SINGLE_STEP_EN adds the WAIT state used for single-stepping.
package control_pkg;

    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_BRA = 4'hB;
    localparam logic [3:0] OP_BZ  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH_L = 3'd0,
        ST_FETCH_H = 3'd1,
        ST_EXEC1   = 3'd2,
        ST_EXEC2   = 3'd3,
        ST_HALT    = 3'd4
`ifdef SINGLE_STEP_EN
        ,ST_WAIT   = 3'd5
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LDI   = 3'd1,
        CLS_LD    = 3'd2,
        CLS_ST    = 3'd3,
        CLS_BRA   = 3'd4,
        CLS_BZ    = 3'd5,
        CLS_HLT   = 3'd6,
        CLS_UNDEF = 3'd7
    } op_class_t;

    localparam logic [1:0] REG_INC    = 2'b01;
    localparam logic [1:0] REG_LOAD   = 2'b10;
    localparam logic [1:0] IR_LOAD    = 2'b01;
    localparam logic [3:0] ALU_PASS_A = 4'b0000;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_AR = 2'b01;

    localparam logic [3:0] REGSEL_NONE = 4'b0000;
    localparam logic [3:0] REGSEL_PC   = 4'b0001;
    localparam logic [3:0] REGSEL_AR   = 4'b0010;

    typedef struct packed {
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] funsel_ir;
        logic       ir_enable;
        logic       ir_lh;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] regsel_arf;
        logic [3:0] regsel_rf;
        logic [3:0] funsel_alu;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic [3:0] rf_tsel;
        logic [1:0] mux_sel_a;
        logic [1:0] mux_sel_b;
        logic       mux_sel_c;
        logic       cs_mem;
        logic       wr_mem;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        outasel: ARF_PC, outbsel: ARF_PC, funsel_ir: 2'b00, ir_enable: 1'b0,
        ir_lh: 1'b0, funsel_arf: 2'b00, funsel_rf: 2'b00,
        regsel_arf: REGSEL_NONE, regsel_rf: REGSEL_NONE, funsel_alu: ALU_PASS_A,
        rf_o1sel: 3'b000, rf_o2sel: 3'b000, rf_tsel: 4'b0000,
        mux_sel_a: MUX_ALU, mux_sel_b: MUX_ALU, mux_sel_c: 1'b0,
        cs_mem: 1'b1, wr_mem: 1'b0
    };

    // R1 is the top bit of the RF enable field, R4 the bottom one.
    function automatic logic [3:0] rf_onehot(input logic [1:0] rx);
        return 4'b1000 >> rx;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational split of the IR into opcode class, register selects and exec-length flag.
import control_pkg::*;

module instr_decode #(
    parameter int DATA_W = 8
) (
    input  logic [2*DATA_W-1:0] ir_in,
    output op_class_t           op_class,
    output logic [3:0]          alu_fn,
    output logic [2:0]          rd_sel,
    output logic [2:0]          rs_sel,
    output logic [3:0]          rd_onehot,
    output logic                is_two_exec
);

    logic [3:0] opcode_s;
    logic [1:0] rd_s;
    logic [1:0] rs_s;
    logic       unused_imm_s;

    assign opcode_s     = ir_in[2*DATA_W-1 -: 4];
    assign rd_s         = ir_in[2*DATA_W-5 -: 2];
    assign rs_s         = ir_in[2*DATA_W-7 -: 2];
    assign unused_imm_s = ^ir_in[DATA_W-1:0];

    assign alu_fn      = {1'b0, opcode_s[2:0]};
    assign rd_sel      = {1'b1, rd_s};
    assign rs_sel      = {1'b1, rs_s};
    assign rd_onehot   = rf_onehot(rd_s);
    assign is_two_exec = (op_class == CLS_LD) || (op_class == CLS_ST);

    // Opcode to instruction class.
    always_comb begin
        op_class = CLS_UNDEF;
        case (opcode_s)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: op_class = CLS_ALU;
            OP_LDI:                 op_class = CLS_LDI;
            OP_LD:                  op_class = CLS_LD;
            OP_ST:                  op_class = CLS_ST;
            OP_BRA:                 op_class = CLS_BRA;
            OP_BZ:                  op_class = CLS_BZ;
            OP_HLT:                 op_class = CLS_HLT;
            default:                op_class = CLS_UNDEF;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving the system datapath controls.
// Optional macro SINGLE_STEP_EN adds the step input and a WAIT state between instructions.
import control_pkg::*;

module control_unit #(
    parameter int DATA_W       = 8,
    parameter bit NOP_ON_UNDEF = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [2*DATA_W-1:0] ir_in,
    input  logic [3:0]          flag,
    output logic [1:0]          outasel,
    output logic [1:0]          outbsel,
    output logic [1:0]          funsel_IR,
    output logic                IR_enable,
    output logic                IR_lh,
    output logic [1:0]          funsel_arf,
    output logic [1:0]          funsel_rf,
    output logic [3:0]          regsel_arf,
    output logic [3:0]          regsel_rf,
    output logic [3:0]          funsel_alu,
    output logic [2:0]          rf_o1sel,
    output logic [2:0]          rf_o2sel,
    output logic [3:0]          rf_tsel,
    output logic [1:0]          MUXSelA,
    output logic [1:0]          MUXSelB,
    output logic                MUXSelC,
    output logic                csMEM,
    output logic                wrMEM,
    output logic                halted,
    output logic                instr_done
);

`ifdef SINGLE_STEP_EN
    localparam state_t DONE_STATE = ST_WAIT;
`else
    localparam state_t DONE_STATE = ST_FETCH_L;
`endif

    state_t     state_r;
    op_class_t  op_class_s;
    logic [3:0] alu_fn_s;
    logic [2:0] rd_sel_s;
    logic [2:0] rs_sel_s;
    logic [3:0] rd_onehot_s;
    logic       is_two_exec_s;
    ctrl_t      ctrl_s;
    logic       done_s;
    logic       unused_flag_s;

    assign unused_flag_s = ^flag[2:0];

    instr_decode #(.DATA_W(DATA_W)) u_decode (
        .ir_in       (ir_in),
        .op_class    (op_class_s),
        .alu_fn      (alu_fn_s),
        .rd_sel      (rd_sel_s),
        .rs_sel      (rs_sel_s),
        .rd_onehot   (rd_onehot_s),
        .is_two_exec (is_two_exec_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH_L;
        end else begin
            case (state_r)
                ST_FETCH_L: state_r <= ST_FETCH_H;
                ST_FETCH_H: state_r <= ST_EXEC1;
                ST_EXEC1: begin
                    if (op_class_s == CLS_HLT) begin
                        state_r <= ST_HALT;
                    end else if ((op_class_s == CLS_UNDEF) && !NOP_ON_UNDEF) begin
                        state_r <= ST_HALT;
                    end else if (is_two_exec_s) begin
                        state_r <= ST_EXEC2;
                    end else begin
                        state_r <= DONE_STATE;
                    end
                end
                ST_EXEC2:   state_r <= DONE_STATE;
                ST_HALT:    state_r <= ST_HALT;
`ifdef SINGLE_STEP_EN
                ST_WAIT:    state_r <= step ? ST_FETCH_L : ST_WAIT;
`endif
                default:    state_r <= ST_FETCH_L;
            endcase
        end
    end

    // Control vector decode; reset overrides everything with the idle vector.
    always_comb begin
        ctrl_s = CTRL_IDLE;
        done_s = 1'b0;
        if (!rst_n) begin
            ctrl_s = CTRL_IDLE;
            done_s = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH_L, ST_FETCH_H: begin
                    ctrl_s.outbsel    = ARF_PC;
                    ctrl_s.cs_mem     = 1'b0;
                    ctrl_s.ir_enable  = 1'b1;
                    ctrl_s.funsel_ir  = IR_LOAD;
                    ctrl_s.ir_lh      = (state_r == ST_FETCH_H);
                    ctrl_s.regsel_arf = REGSEL_PC;
                    ctrl_s.funsel_arf = REG_INC;
                end
                ST_EXEC1: begin
                    done_s = !is_two_exec_s;
                    case (op_class_s)
                        CLS_ALU: begin
                            ctrl_s.rf_o1sel   = rd_sel_s;
                            ctrl_s.rf_o2sel   = rs_sel_s;
                            ctrl_s.mux_sel_c  = 1'b1;
                            ctrl_s.funsel_alu = alu_fn_s;
                            ctrl_s.mux_sel_a  = MUX_ALU;
                            ctrl_s.regsel_rf  = rd_onehot_s;
                            ctrl_s.funsel_rf  = REG_LOAD;
                        end
                        CLS_LDI: begin
                            ctrl_s.mux_sel_a = MUX_IMM;
                            ctrl_s.regsel_rf = rd_onehot_s;
                            ctrl_s.funsel_rf = REG_LOAD;
                        end
                        CLS_LD, CLS_ST: begin
                            ctrl_s.mux_sel_b  = MUX_IMM;
                            ctrl_s.regsel_arf = REGSEL_AR;
                            ctrl_s.funsel_arf = REG_LOAD;
                        end
                        CLS_BRA: begin
                            ctrl_s.mux_sel_b  = MUX_IMM;
                            ctrl_s.regsel_arf = REGSEL_PC;
                            ctrl_s.funsel_arf = REG_LOAD;
                        end
                        CLS_BZ: begin
                            if (flag[3]) begin
                                ctrl_s.mux_sel_b  = MUX_IMM;
                                ctrl_s.regsel_arf = REGSEL_PC;
                                ctrl_s.funsel_arf = REG_LOAD;
                            end else begin
                                ctrl_s = CTRL_IDLE;
                            end
                        end
                        default: ctrl_s = CTRL_IDLE;
                    endcase
                end
                ST_EXEC2: begin
                    done_s         = 1'b1;
                    ctrl_s.outbsel = ARF_AR;
                    ctrl_s.cs_mem  = 1'b0;
                    if (op_class_s == CLS_ST) begin
                        ctrl_s.rf_o1sel   = rs_sel_s;
                        ctrl_s.mux_sel_c  = 1'b1;
                        ctrl_s.funsel_alu = ALU_PASS_A;
                        ctrl_s.wr_mem     = 1'b1;
                    end else begin
                        ctrl_s.mux_sel_a = MUX_MEM;
                        ctrl_s.regsel_rf = rd_onehot_s;
                        ctrl_s.funsel_rf = REG_LOAD;
                    end
                end
                default: begin
                    ctrl_s = CTRL_IDLE;
                    done_s = 1'b0;
                end
            endcase
        end
    end

    assign outasel    = ctrl_s.outasel;
    assign outbsel    = ctrl_s.outbsel;
    assign funsel_IR  = ctrl_s.funsel_ir;
    assign IR_enable  = ctrl_s.ir_enable;
    assign IR_lh      = ctrl_s.ir_lh;
    assign funsel_arf = ctrl_s.funsel_arf;
    assign funsel_rf  = ctrl_s.funsel_rf;
    assign regsel_arf = ctrl_s.regsel_arf;
    assign regsel_rf  = ctrl_s.regsel_rf;
    assign funsel_alu = ctrl_s.funsel_alu;
    assign rf_o1sel   = ctrl_s.rf_o1sel;
    assign rf_o2sel   = ctrl_s.rf_o2sel;
    assign rf_tsel    = ctrl_s.rf_tsel;
    assign MUXSelA    = ctrl_s.mux_sel_a;
    assign MUXSelB    = ctrl_s.mux_sel_b;
    assign MUXSelC    = ctrl_s.mux_sel_c;
    assign csMEM      = ctrl_s.cs_mem;
    assign wrMEM      = ctrl_s.wr_mem;
    assign halted     = rst_n && (state_r == ST_HALT);
    assign instr_done = done_s;

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-instruction cycle model.
// Optional macro SINGLE_STEP_EN enables the step-port scenario.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir_in = 16'h0000;
    logic [3:0]  flag = 4'b0000;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    logic [1:0] outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, MUXSelA, MUXSelB;
    logic       IR_enable, IR_lh, MUXSelC, csMEM, wrMEM, halted, instr_done;
    logic [3:0] regsel_arf, regsel_rf, funsel_alu, rf_tsel;
    logic [2:0] rf_o1sel, rf_o2sel;

    int n_vec = 0;
    int n_err = 0;

    // Packed view: ...,csMEM(bit3),wrMEM(bit2),halted(bit1),instr_done(bit0).
    localparam logic [42:0] IDLE_V = 43'd8;
    localparam logic [42:0] HALT_V = 43'd10;

    wire [42:0] obs = {outasel, outbsel, funsel_IR, IR_enable, IR_lh, funsel_arf, funsel_rf,
                       regsel_arf, regsel_rf, funsel_alu, rf_o1sel, rf_o2sel, rf_tsel,
                       MUXSelA, MUXSelB, MUXSelC, csMEM, wrMEM, halted, instr_done};

    control_unit dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .ir_in(ir_in), .flag(flag),
        .outasel(outasel), .outbsel(outbsel), .funsel_IR(funsel_IR),
        .IR_enable(IR_enable), .IR_lh(IR_lh), .funsel_arf(funsel_arf), .funsel_rf(funsel_rf),
        .regsel_arf(regsel_arf), .regsel_rf(regsel_rf), .funsel_alu(funsel_alu),
        .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .rf_tsel(rf_tsel),
        .MUXSelA(MUXSelA), .MUXSelB(MUXSelB), .MUXSelC(MUXSelC),
        .csMEM(csMEM), .wrMEM(wrMEM), .halted(halted), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    function automatic int n_cycles(input logic [15:0] ir);
        return (ir[15:12] == 4'h9 || ir[15:12] == 4'hA) ? 4 : 3;
    endfunction

    // Expected outputs in cycle k (0 = low fetch) of instruction ir.
    function automatic logic [42:0] model(input logic [15:0] ir, input logic [3:0] fl, input int k);
        logic [1:0] outa, outb, fir, farf, frf, msa, msb;
        logic       iren, irlh, msc, cs, wr, done;
        logic [3:0] rarf, rrf, falu, tsel, op;
        logic [2:0] o1, o2;
        outa = 2'b00; outb = 2'b00; fir = 2'b00; farf = 2'b00; frf = 2'b00;
        msa = 2'b00; msb = 2'b00; iren = 1'b0; irlh = 1'b0; msc = 1'b0;
        cs = 1'b1; wr = 1'b0; rarf = 4'b0000; rrf = 4'b0000; falu = 4'b0000;
        tsel = 4'b0000; o1 = 3'b000; o2 = 3'b000;
        op = ir[15:12];
        if (k < 2) begin
            cs = 1'b0; iren = 1'b1; fir = 2'b01; irlh = (k == 1);
            rarf = 4'b0001; farf = 2'b01;
        end else if (k == 2) begin
            if (op <= 4'h7) begin
                o1 = {1'b1, ir[11:10]}; o2 = {1'b1, ir[9:8]}; msc = 1'b1;
                falu = {1'b0, op[2:0]}; rrf = 4'b1000 >> ir[11:10]; frf = 2'b10;
            end else if (op == 4'h8) begin
                msa = 2'b10; rrf = 4'b1000 >> ir[11:10]; frf = 2'b10;
            end else if (op == 4'h9 || op == 4'hA) begin
                msb = 2'b10; rarf = 4'b0010; farf = 2'b10;
            end else if (op == 4'hB || (op == 4'hC && fl[3])) begin
                msb = 2'b10; rarf = 4'b0001; farf = 2'b10;
            end
        end else if (op == 4'h9) begin
            outb = 2'b01; cs = 1'b0; msa = 2'b01; rrf = 4'b1000 >> ir[11:10]; frf = 2'b10;
        end else begin
            outb = 2'b01; cs = 1'b0; wr = 1'b1; o1 = {1'b1, ir[9:8]}; msc = 1'b1;
        end
        done = (k == n_cycles(ir) - 1);
        return {outa, outb, fir, iren, irlh, farf, frf, rarf, rrf, falu, o1, o2, tsel,
                msa, msb, msc, cs, wr, 1'b0, done};
    endfunction

    // Inter-instruction gap (WAIT with step held high) when single-stepping is built in.
    task automatic wait_gap();
`ifdef SINGLE_STEP_EN
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ir_in = 16'($urandom); flag = 4'($urandom);
            @(negedge clk); #1;
            n_vec++;
            if (obs !== IDLE_V) begin
                n_err++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, IDLE_V);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ldi();
        logic [15:0] ir = 16'h8105;
        for (int k = 0; k < n_cycles(ir); k++) begin
            ir_in = ir; flag = 4'b0000; #1;
            n_vec++;
            if (obs !== model(ir, 4'b0000, k)) begin
                n_err++; $display("FAIL ldi k=%0d got=%h exp=%h", k, obs, model(ir, 4'b0000, k));
            end
            @(negedge clk);
        end
        wait_gap();
    endtask

    task automatic test_alu();
        logic [15:0] ir;
        logic [3:0]  fl;
        for (int t = 0; t < 10; t++) begin
            ir = (t == 0) ? 16'h3600 : {1'b0, 15'($urandom)};
            fl = 4'($urandom);
            for (int k = 0; k < n_cycles(ir); k++) begin
                ir_in = ir; flag = fl; #1;
                n_vec++;
                if (obs !== model(ir, fl, k)) begin
                    n_err++; $display("FAIL alu ir=%h k=%0d got=%h exp=%h", ir, k, obs, model(ir, fl, k));
                end
                @(negedge clk);
            end
            wait_gap();
        end
    endtask

    task automatic test_st();
        logic [15:0] ir;
        for (int t = 0; t < 4; t++) begin
            ir = (t == 0) ? 16'hA040 : {4'hA, 12'($urandom)};
            for (int k = 0; k < n_cycles(ir); k++) begin
                ir_in = ir; flag = 4'($urandom); #1;
                n_vec++;
                if (obs !== model(ir, flag, k)) begin
                    n_err++; $display("FAIL st ir=%h k=%0d got=%h exp=%h", ir, k, obs, model(ir, flag, k));
                end
                @(negedge clk);
            end
            wait_gap();
        end
    endtask

    task automatic test_bz();
        logic [15:0] ir = 16'hC020;
        logic [3:0]  fl;
        for (int t = 0; t < 6; t++) begin
            fl = (t == 0) ? 4'b1000 : (t == 1) ? 4'b0000 : 4'($urandom);
            for (int k = 0; k < n_cycles(ir); k++) begin
                ir_in = ir; flag = fl; #1;
                n_vec++;
                if (obs !== model(ir, fl, k)) begin
                    n_err++; $display("FAIL bz flag=%b k=%0d got=%h exp=%h", fl, k, obs, model(ir, fl, k));
                end
                @(negedge clk);
            end
            wait_gap();
        end
    endtask

    task automatic test_random_mix();
        logic [15:0] ir;
        logic [3:0]  fl;
        for (int t = 0; t < 60; t++) begin
            ir = 16'($urandom);
            if (ir[15:12] == 4'hF) ir[15:12] = 4'hD;
            fl = 4'($urandom);
            for (int k = 0; k < n_cycles(ir); k++) begin
                ir_in = ir; flag = fl; #1;
                n_vec++;
                if (obs !== model(ir, fl, k)) begin
                    n_err++; $display("FAIL mix ir=%h k=%0d got=%h exp=%h", ir, k, obs, model(ir, fl, k));
                end
                @(negedge clk);
            end
            wait_gap();
        end
    endtask

    task automatic test_ld_reset();
        logic [15:0] ir = {4'h9, 12'($urandom)};
        for (int k = 0; k < 3; k++) begin
            ir_in = ir; flag = 4'b0000; #1;
            n_vec++;
            if (obs !== model(ir, 4'b0000, k)) begin
                n_err++; $display("FAIL ld k=%0d got=%h exp=%h", k, obs, model(ir, 4'b0000, k));
            end
            @(negedge clk);
        end
        rst_n = 1'b0; #1;
        n_vec++;
        if (obs !== IDLE_V) begin
            n_err++; $display("FAIL ld_rst_idle got=%h exp=%h", obs, IDLE_V);
        end
        @(negedge clk); #1;
        n_vec++;
        if (obs !== IDLE_V) begin
            n_err++; $display("FAIL ld_rst_hold got=%h exp=%h", obs, IDLE_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ir = {4'h8, 12'($urandom)};
        for (int k = 0; k < n_cycles(ir); k++) begin
            ir_in = ir; #1;
            n_vec++;
            if (obs !== model(ir, flag, k)) begin
                n_err++; $display("FAIL ld_rst_refetch k=%0d got=%h exp=%h", k, obs, model(ir, flag, k));
            end
            @(negedge clk);
        end
        wait_gap();
    endtask

    task automatic test_halt();
        logic [15:0] ir = 16'hF0A5;
        for (int k = 0; k < n_cycles(ir); k++) begin
            ir_in = ir; #1;
            n_vec++;
            if (obs !== model(ir, flag, k)) begin
                n_err++; $display("FAIL hlt k=%0d got=%h exp=%h", k, obs, model(ir, flag, k));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            ir_in = 16'($urandom); flag = 4'($urandom); #1;
            n_vec++;
            if (obs !== HALT_V) begin
                n_err++; $display("FAIL halt_idle cyc=%0d got=%h exp=%h", i, obs, HALT_V);
            end
            @(negedge clk);
        end
        rst_n = 1'b0; #1;
        n_vec++;
        if (obs !== IDLE_V) begin
            n_err++; $display("FAIL halt_rst got=%h exp=%h", obs, IDLE_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ir = 16'h8E33;
        for (int k = 0; k < n_cycles(ir); k++) begin
            ir_in = ir; #1;
            n_vec++;
            if (obs !== model(ir, flag, k)) begin
                n_err++; $display("FAIL halt_resume k=%0d got=%h exp=%h", k, obs, model(ir, flag, k));
            end
            @(negedge clk);
        end
        wait_gap();
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_step();
        logic [15:0] ir = 16'h8105;
        for (int k = 0; k < 3; k++) begin
            ir_in = ir; step = (k == 2) ? 1'b0 : 1'b1; #1;
            n_vec++;
            if (obs !== model(ir, flag, k)) begin
                n_err++; $display("FAIL step_ldi k=%0d got=%h exp=%h", k, obs, model(ir, flag, k));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (obs !== IDLE_V) begin
                n_err++; $display("FAIL step_wait cyc=%0d got=%h exp=%h", i, obs, IDLE_V);
            end
            @(negedge clk);
        end
        step = 1'b1; #1;
        n_vec++;
        if (obs !== IDLE_V) begin
            n_err++; $display("FAIL step_release got=%h exp=%h", obs, IDLE_V);
        end
        @(negedge clk); #1;
        n_vec++;
        if (obs !== model(ir, flag, 0)) begin
            n_err++; $display("FAIL step_fetch got=%h exp=%h", obs, model(ir, flag, 0));
        end
        for (int k = 1; k < 3; k++) @(negedge clk);
        @(negedge clk);
        wait_gap();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_ldi();
        test_alu();
        test_st();
        test_bz();
        test_random_mix();
        test_ld_reset();
`ifdef SINGLE_STEP_EN
        test_step();
`endif
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Hardwired sequencer that drives the `system` datapath's control inputs, which benches currently toggle by hand. Each instruction is a two-byte fetch from memory at PC into the IR (low byte, then high byte), followed by one or two execute cycles decoded from the IR. The block sits beside `system`. It reads the IR and the ALU flags, and drives every datapath select, enable and memory strobe.

Parameters:
- DATA_W, 8, datapath byte width; IR width is 2*DATA_W.
- NOP_ON_UNDEF, 1, 1 = undefined opcodes execute as NOP; 0 = undefined opcodes enter HALT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ir_in  in  16  IR contents: [15:12] opcode, [11:10] Rd, [9:8] Rs, [7:0] imm.
- flag  in  4  ALU flags {Z,C,N,O}.
- outasel, outbsel  out  2  ARF output selects: 00 PC, 01 AR, 10 SP.
- funsel_IR  out  2  IR function select; 01 loads the byte chosen by IR_lh.
- IR_enable, IR_lh  out  1  IR enable; byte select (0 low, 1 high).
- funsel_arf, funsel_rf  out  2  register function: 00 dec, 01 inc, 10 load, 11 clear.
- regsel_arf, regsel_rf  out  4  one-hot register enables, active-high; 0000 selects none.
- funsel_alu  out  4  ALU operation; 0000 passes A.
- rf_o1sel, rf_o2sel  out  3  RF read selects; {1,Rx} selects R1..R4.
- rf_tsel  out  4  temp-register enables; constant 0000.
- MUXSelA  out  2  RF input: 00 ALU, 01 memory, 10 imm, 11 ARF OutA.
- MUXSelB  out  2  ARF input, same encoding as MUXSelA.
- MUXSelC  out  1  ALU A input: 0 ARF OutA, 1 RF O1.
- csMEM  out  1  memory select, active-low.
- wrMEM  out  1  memory write strobe (1 = write).
- halted  out  1  high while in HALT.
- instr_done  out  1  one-cycle pulse in an instruction's last cycle.

Behaviour:
- State register: FETCH_L, FETCH_H, EXEC1, EXEC2, HALT.
- Outputs are combinational from the state register and ir_in; the datapath samples them on the next rising edge.
- Idle vector: all enables 0, regsel 0000, csMEM=1, wrMEM=0, remaining selects 0.
- While rst_n=0: outputs forced to the idle vector and halted=0; state returns to FETCH_L immediately, even mid-instruction. Fetch resumes on the first edge after release.
- FETCH_L: outbsel=PC; csMEM=0, wrMEM=0; IR_enable=1, funsel_IR=01, IR_lh=0; PC incremented (regsel_arf=PC, funsel_arf=01). Next state FETCH_H.
- FETCH_H: same as FETCH_L with IR_lh=1. Next state EXEC1.
- Opcodes 0x0-0x7 (ALU), EXEC1:
  - rf_o1sel={1,Rd}, rf_o2sel={1,Rs}, MUXSelC=1, funsel_alu={0,op[2:0]}.
  - MUXSelA=00, Rd loaded.
  - Next state FETCH_L.
- 0x8 LDI, EXEC1: MUXSelA=10, Rd loaded. Next state FETCH_L.
- 0x9 LD:
  - EXEC1: MUXSelB=10, AR loaded.
  - EXEC2: outbsel=AR, csMEM=0, wrMEM=0, MUXSelA=01, Rd loaded.
- 0xA ST:
  - EXEC1: AR loaded with imm, as in LD.
  - EXEC2: outbsel=AR, rf_o1sel={1,Rs}, MUXSelC=1, funsel_alu=0000, csMEM=0, wrMEM=1.
- 0xB BRA, EXEC1: MUXSelB=10, PC loaded.
- 0xC BZ, EXEC1: performs BRA only if flag[3]=1; otherwise idle vector.
- 0xF HLT, EXEC1: next state HALT. HALT drives the idle vector until reset.
- 0xD, 0xE: NOP (idle EXEC1) or HALT, per NOP_ON_UNDEF.
- Latency: 3 cycles for ALU, LDI, BRA, BZ and NOP; 4 cycles for LD and ST.
- instr_done is high in EXEC1 for 3-cycle instructions and in EXEC2 for 4-cycle ones.
- Rd==Rs is legal. The ALU reads old values; the write lands at the edge.
- Flags are consumed as presented in EXEC1; the prior ALU instruction updated them at its edge.

Optional Feature:
- Macro SINGLE_STEP_EN:
  - Defined: adds input step (1 bit) and state WAIT. After instr_done the FSM enters WAIT, driving the idle vector, and moves to FETCH_L on the cycle after step=1. A step held high advances one instruction per fetch.
  - Undefined: no port and no WAIT state; runs freely.

Decomposition:
- control_pkg holds:
  - opcode constants and state enum;
  - funsel encodings for registers, IR and ALU;
  - MUXSel encodings and ARF indices (PC/AR/SP);
  - the idle control vector constant.
- One sub-module, instr_decode: combinational split of ir_in into opcode class, Rd/Rs selects, one-hot regsel, and an is_two_exec flag.

Test Plan:
- Reset, then memory[0..1]={0x05,0x81} (LDI R1,0x05) -> regsel_arf=0001 with funsel_arf=01 at T0 and T1; MUXSelA=10, regsel_rf=1000 (R1) at T2; instr_done at cycle 3.
- ALU op 0x3 with Rd=R2, Rs=R3 -> funsel_alu=0011, rf_o1sel=101, rf_o2sel=110, MUXSelC=1 in EXEC1; state returns to FETCH_L.
- ST R1,0x40 -> EXEC1 AR loaded, then EXEC2 csMEM=0, wrMEM=1, outbsel=01; total 4 cycles.
- BZ 0x20: with flag=4'b1000, regsel_arf selects PC with funsel_arf=10 -> taken; with flag=4'b0000, idle vector -> not taken.
- HLT: halted=1 and outputs stay idle for 20 cycles; rst_n pulsed in the middle of EXEC2 of an LD -> outputs go idle immediately and fetch restarts after release.
- With SINGLE_STEP_EN: after LDI, the FSM holds in WAIT until step=1, then FETCH_L follows on the next cycle.
